rob: RTL and testbench

Reorder buffer. Tracks up to 8 in-flight instructions in program order and retires them in order. Drives `ld_commit`/`st_commit`, `mispredict`, `flush_mask` and `mis_ld_idx`/`mis_st_idx` into the LSU, and consumes the LSU's `LQ_tail`/`SQ_tail` snapshots. It sits between dispatch (allocation), the execute/writeback ports (completion) and branch resolution (flush).

---
 rtl/ooo_pkg.sv | 29 ++
 rtl/rob_age_mask.sv | 26 ++
 rtl/rob.sv | 134 +++++++++++++
 tb/tb_rob.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ooo_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | ooo_pkg : shared constants, ROB entry type and age helper            |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package ooo_pkg;

  localparam int         ROB_DEPTH = 8;
  localparam logic [2:0] FU_LD     = 3'd6;
  localparam logic [2:0] FU_ST     = 3'd7;
  localparam logic [2:0] FU_BR     = 3'd5;

  typedef struct packed {
    logic       valid;
    logic       done;
    logic       is_ld;
    logic       is_st;
    logic [6:0] rd;
    logic [1:0] lq_snap;
    logic [1:0] sq_snap;
  } rob_entry_t;

  // Distance from head in program order; 3-bit wrap is intentional.
  function automatic logic [2:0] rob_age(input logic [2:0] idx, input logic [2:0] head);
    return idx - head;
  endfunction

endpackage
`default_nettype wire

// File: rtl/rob_age_mask.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | rob_age_mask : marks valid entries younger than the resolving branch |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module rob_age_mask
  import ooo_pkg::*;
(
  input  logic [2:0]           head,
  input  logic [2:0]           br_rob_idx,
  input  logic [ROB_DEPTH-1:0] valid,
  output logic [ROB_DEPTH-1:0] flush_mask
);

  logic [2:0] w_br_age;

  always_comb begin
    w_br_age   = rob_age(br_rob_idx, head);
    flush_mask = '0;
    for (int i = 0; i < ROB_DEPTH; i++) begin
      flush_mask[i] = valid[i] && (rob_age(3'(i), head) > w_br_age);
    end
  end

endmodule
`default_nettype wire

// File: rtl/rob.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | rob : 8-entry reorder buffer, in-order retire, branch flush to LSU   |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module rob
  import ooo_pkg::*;
#(
  parameter int DEPTH = ROB_DEPTH
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       decode_valid,
  input  logic [2:0] DC_fu_sel,
  input  logic [6:0] DC_rd,
  input  logic [1:0] LQ_tail,
  input  logic [1:0] SQ_tail,
  output logic [2:0] DC_rob_idx,
  output logic       rob_ready,
  input  logic       alu_wb_valid,
  input  logic [2:0] alu_wb_rob_idx,
  input  logic       ld_o_valid,
  input  logic [2:0] ld_o_rob_idx,
  input  logic       st_done_valid,
  input  logic [2:0] st_done_rob_idx,
  input  logic       br_valid,
  input  logic [2:0] br_rob_idx,
  input  logic       br_mispredict,
  output logic       ld_commit,
  output logic       st_commit,
  output logic       commit_valid,
  output logic [6:0] commit_rd,
  output logic       mispredict,
  output logic [7:0] flush_mask,
  output logic [1:0] mis_ld_idx,
  output logic [1:0] mis_st_idx
);

  rob_entry_t       entries_q [DEPTH];
  rob_entry_t       entries_d [DEPTH];
  logic [2:0]       head_q, head_d;
  logic [2:0]       tail_q, tail_d;
  logic [3:0]       count_q, count_d;

  logic [DEPTH-1:0] w_valid;
  logic [DEPTH-1:0] w_raw_mask;
  logic             w_alloc;
  logic             w_retire;
  logic [2:0]       w_br_age;
  rob_entry_t       w_head;

  always_comb begin
    for (int i = 0; i < DEPTH; i++) w_valid[i] = entries_q[i].valid;
  end

  rob_age_mask u_age_mask (
    .head       (head_q),
    .br_rob_idx (br_rob_idx),
    .valid      (w_valid),
    .flush_mask (w_raw_mask)
  );

  always_comb begin
    entries_d = entries_q;
    head_d    = head_q;
    tail_d    = tail_q;
    count_d   = count_q;

    mispredict = br_valid && br_mispredict;
    rob_ready  = (count_q != 4'd8);
    DC_rob_idx = tail_q;
    w_alloc    = decode_valid && rob_ready && !mispredict;
    w_br_age   = rob_age(br_rob_idx, head_q);

    w_head       = entries_q[head_q];
    w_retire     = w_head.valid && w_head.done;
    commit_valid = w_retire;
    commit_rd    = w_retire ? w_head.rd : 7'd0;
    ld_commit    = w_retire && w_head.is_ld;
    st_commit    = w_retire && w_head.is_st;

    flush_mask = mispredict ? w_raw_mask : '0;
    mis_ld_idx = mispredict ? entries_q[br_rob_idx].lq_snap : 2'd0;
    mis_st_idx = mispredict ? entries_q[br_rob_idx].sq_snap : 2'd0;

    // Writebacks to invalid (flushed or not yet allocated) slots are dropped.
    if (alu_wb_valid && entries_q[alu_wb_rob_idx].valid)   entries_d[alu_wb_rob_idx].done  = 1'b1;
    if (ld_o_valid && entries_q[ld_o_rob_idx].valid)       entries_d[ld_o_rob_idx].done    = 1'b1;
    if (st_done_valid && entries_q[st_done_rob_idx].valid) entries_d[st_done_rob_idx].done = 1'b1;
    if (br_valid && entries_q[br_rob_idx].valid)           entries_d[br_rob_idx].done      = 1'b1;

    if (w_alloc) begin
      entries_d[tail_q] = '{valid:   1'b1,
                            done:    1'b0,
                            is_ld:   (DC_fu_sel == FU_LD),
                            is_st:   (DC_fu_sel == FU_ST),
                            rd:      DC_rd,
                            lq_snap: LQ_tail,
                            sq_snap: SQ_tail};
      tail_d = tail_q + 3'd1;
    end

    if (w_retire) begin
      entries_d[head_q] = '0;
      head_d            = head_q + 3'd1;
    end

    if (mispredict) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (flush_mask[i]) entries_d[i] = '0;
      end
      tail_d  = br_rob_idx + 3'd1;
      count_d = {1'b0, w_br_age} + 4'd1 - {3'b0, w_retire};
    end else begin
      count_d = count_q + {3'b0, w_alloc} - {3'b0, w_retire};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) entries_q[i] <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) entries_q[i] <= entries_d[i];
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_rob.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_rob : directed self-checking bench for the reorder buffer         |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_rob;

  logic       clk, rst;
  logic       decode_valid;
  logic [2:0] DC_fu_sel;
  logic [6:0] DC_rd;
  logic [1:0] LQ_tail, SQ_tail;
  logic [2:0] DC_rob_idx;
  logic       rob_ready;
  logic       alu_wb_valid;
  logic [2:0] alu_wb_rob_idx;
  logic       ld_o_valid;
  logic [2:0] ld_o_rob_idx;
  logic       st_done_valid;
  logic [2:0] st_done_rob_idx;
  logic       br_valid;
  logic [2:0] br_rob_idx;
  logic       br_mispredict;
  logic       ld_commit, st_commit, commit_valid, mispredict;
  logic [6:0] commit_rd;
  logic [7:0] flush_mask;
  logic [1:0] mis_ld_idx, mis_st_idx;

  int n_checks = 0;
  int n_fail   = 0;

  rob dut (
    .clk(clk), .rst(rst),
    .decode_valid(decode_valid), .DC_fu_sel(DC_fu_sel), .DC_rd(DC_rd),
    .LQ_tail(LQ_tail), .SQ_tail(SQ_tail),
    .DC_rob_idx(DC_rob_idx), .rob_ready(rob_ready),
    .alu_wb_valid(alu_wb_valid), .alu_wb_rob_idx(alu_wb_rob_idx),
    .ld_o_valid(ld_o_valid), .ld_o_rob_idx(ld_o_rob_idx),
    .st_done_valid(st_done_valid), .st_done_rob_idx(st_done_rob_idx),
    .br_valid(br_valid), .br_rob_idx(br_rob_idx), .br_mispredict(br_mispredict),
    .ld_commit(ld_commit), .st_commit(st_commit),
    .commit_valid(commit_valid), .commit_rd(commit_rd),
    .mispredict(mispredict), .flush_mask(flush_mask),
    .mis_ld_idx(mis_ld_idx), .mis_st_idx(mis_st_idx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    decode_valid  = 1'b0; DC_fu_sel = 3'd0; DC_rd = 7'd0;
    LQ_tail       = 2'd0; SQ_tail   = 2'd0;
    alu_wb_valid  = 1'b0; alu_wb_rob_idx  = 3'd0;
    ld_o_valid    = 1'b0; ld_o_rob_idx    = 3'd0;
    st_done_valid = 1'b0; st_done_rob_idx = 3'd0;
    br_valid      = 1'b0; br_rob_idx = 3'd0; br_mispredict = 1'b0;
  endtask

  task automatic do_reset();
    idle();
    #2 rst = 1'b1;
    #2 rst = 1'b0;
    tick();
  endtask

  task automatic dispatch(input logic [2:0] fu, input logic [6:0] rd,
                          input logic [1:0] lq, input logic [1:0] sq);
    decode_valid = 1'b1; DC_fu_sel = fu; DC_rd = rd; LQ_tail = lq; SQ_tail = sq;
    tick();
    idle();
  endtask

  task automatic test_reset();
    dispatch(3'd0, 7'd1, 2'd0, 2'd0);
    dispatch(3'd0, 7'd2, 2'd0, 2'd0);
    alu_wb_valid = 1'b1; alu_wb_rob_idx = 3'd0;
    tick();
    idle();
    #1;
    n_checks++;
    if (commit_valid !== 1'b1) begin n_fail++; $display("FAIL reset_pre commit_valid got %0b want 1", commit_valid); end
    #2 rst = 1'b1;
    #1;
    n_checks++;
    if (DC_rob_idx !== 3'd0 || rob_ready !== 1'b1) begin
      n_fail++; $display("FAIL reset_idx_ready got idx=%0d rdy=%0b want idx=0 rdy=1", DC_rob_idx, rob_ready);
    end
    n_checks++;
    if ({commit_valid, commit_rd, ld_commit, st_commit} !== 10'd0) begin
      n_fail++; $display("FAIL reset_commit got cv=%0b rd=%0d ld=%0b st=%0b want 0", commit_valid, commit_rd, ld_commit, st_commit);
    end
    n_checks++;
    if ({mispredict, flush_mask, mis_ld_idx, mis_st_idx} !== 13'd0 || dut.count_q !== 4'd0) begin
      n_fail++; $display("FAIL reset_flush got mp=%0b mask=%b ld=%0d st=%0d cnt=%0d want 0", mispredict, flush_mask, mis_ld_idx, mis_st_idx, dut.count_q);
    end
    #2 rst = 1'b0;
    tick();
  endtask

  task automatic test_fill();
    do_reset();
    for (int k = 0; k < 8; k++) begin
      decode_valid = 1'b1; DC_rd = 7'(10 + k);
      #1;
      n_checks++;
      if (DC_rob_idx !== 3'(k) || rob_ready !== 1'b1) begin
        n_fail++; $display("FAIL fill_idx%0d got idx=%0d rdy=%0b want idx=%0d rdy=1", k, DC_rob_idx, rob_ready, k);
      end
      tick();
    end
    idle();
    #1;
    n_checks++;
    if (rob_ready !== 1'b0) begin n_fail++; $display("FAIL fill_full rob_ready got %0b want 0", rob_ready); end
    alu_wb_valid = 1'b1; alu_wb_rob_idx = 3'd0;
    tick();
    idle();
    decode_valid = 1'b1; DC_rd = 7'd20;
    #1;
    n_checks++;
    if (commit_valid !== 1'b1 || commit_rd !== 7'd10 || rob_ready !== 1'b0) begin
      n_fail++; $display("FAIL fill_refuse got cv=%0b rd=%0d rdy=%0b want cv=1 rd=10 rdy=0", commit_valid, commit_rd, rob_ready);
    end
    tick();
    #1;
    n_checks++;
    if (rob_ready !== 1'b1 || DC_rob_idx !== 3'd0 || commit_valid !== 1'b0) begin
      n_fail++; $display("FAIL fill_accept got rdy=%0b idx=%0d cv=%0b want rdy=1 idx=0 cv=0", rob_ready, DC_rob_idx, commit_valid);
    end
    tick();
    idle();
    #1;
    n_checks++;
    if (rob_ready !== 1'b0 || DC_rob_idx !== 3'd1) begin
      n_fail++; $display("FAIL fill_refull got rdy=%0b idx=%0d want rdy=0 idx=1", rob_ready, DC_rob_idx);
    end
  endtask

  task automatic test_ooo();
    logic [2:0] wb_order [3];
    logic [6:0] rd_exp;
    wb_order[0] = 3'd2; wb_order[1] = 3'd1; wb_order[2] = 3'd0;
    do_reset();
    for (int k = 0; k < 3; k++) dispatch(3'd0, 7'(30 + k), 2'd0, 2'd0);
    for (int k = 0; k < 3; k++) begin
      alu_wb_valid = 1'b1; alu_wb_rob_idx = wb_order[k];
      #1;
      n_checks++;
      if (commit_valid !== 1'b0) begin n_fail++; $display("FAIL ooo_early%0d commit_valid got %0b want 0", k, commit_valid); end
      tick();
    end
    idle();
    for (int k = 0; k < 3; k++) begin
      rd_exp = 7'(30 + k);
      #1;
      n_checks++;
      if (commit_valid !== 1'b1 || commit_rd !== rd_exp) begin
        n_fail++; $display("FAIL ooo_retire%0d got cv=%0b rd=%0d want cv=1 rd=%0d", k, commit_valid, commit_rd, rd_exp);
      end
      tick();
    end
    #1;
    n_checks++;
    if (commit_valid !== 1'b0 || dut.count_q !== 4'd0) begin
      n_fail++; $display("FAIL ooo_drain got cv=%0b cnt=%0d want cv=0 cnt=0", commit_valid, dut.count_q);
    end
  endtask

  task automatic test_ldst();
    do_reset();
    dispatch(3'd6, 7'd40, 2'd0, 2'd0);
    dispatch(3'd7, 7'd41, 2'd1, 2'd0);
    ld_o_valid = 1'b1; ld_o_rob_idx = 3'd0;
    st_done_valid = 1'b1; st_done_rob_idx = 3'd1;
    tick();
    idle();
    #1;
    n_checks++;
    if ({ld_commit, st_commit} !== 2'b10 || commit_rd !== 7'd40) begin
      n_fail++; $display("FAIL ldst_ld got ld=%0b st=%0b rd=%0d want ld=1 st=0 rd=40", ld_commit, st_commit, commit_rd);
    end
    tick();
    #1;
    n_checks++;
    if ({ld_commit, st_commit} !== 2'b01 || commit_rd !== 7'd41) begin
      n_fail++; $display("FAIL ldst_st got ld=%0b st=%0b rd=%0d want ld=0 st=1 rd=41", ld_commit, st_commit, commit_rd);
    end
    tick();
    #1;
    n_checks++;
    if ({ld_commit, st_commit, commit_valid} !== 3'b000) begin
      n_fail++; $display("FAIL ldst_done got ld=%0b st=%0b cv=%0b want 0", ld_commit, st_commit, commit_valid);
    end
  endtask

  task automatic test_wrap_mispredict();
    do_reset();
    for (int k = 0; k < 6; k++) begin
      dispatch(3'd0, 7'd0, 2'd0, 2'd0);
      alu_wb_valid = 1'b1; alu_wb_rob_idx = 3'(k);
      tick();
      idle();
      tick();
    end
    #1;
    n_checks++;
    if (DC_rob_idx !== 3'd6 || dut.count_q !== 4'd0) begin
      n_fail++; $display("FAIL wrap_setup got idx=%0d cnt=%0d want idx=6 cnt=0", DC_rob_idx, dut.count_q);
    end
    dispatch(3'd0, 7'd50, 2'd3, 2'd3);
    dispatch(3'd5, 7'd51, 2'd2, 2'd1);
    dispatch(3'd0, 7'd52, 2'd3, 2'd3);
    dispatch(3'd0, 7'd53, 2'd3, 2'd3);
    br_valid = 1'b1; br_rob_idx = 3'd7; br_mispredict = 1'b1;
    #1;
    n_checks++;
    if (mispredict !== 1'b1 || flush_mask !== 8'b0000_0011 || mis_ld_idx !== 2'd2 || mis_st_idx !== 2'd1) begin
      n_fail++; $display("FAIL wrap_mask got mp=%0b mask=%b ld=%0d st=%0d want mp=1 mask=00000011 ld=2 st=1", mispredict, flush_mask, mis_ld_idx, mis_st_idx);
    end
    tick();
    idle();
    #1;
    n_checks++;
    if (DC_rob_idx !== 3'd0 || dut.count_q !== 4'd2 || mispredict !== 1'b0) begin
      n_fail++; $display("FAIL wrap_after got tail=%0d cnt=%0d mp=%0b want tail=0 cnt=2 mp=0", DC_rob_idx, dut.count_q, mispredict);
    end
    alu_wb_valid = 1'b1; alu_wb_rob_idx = 3'd6;
    ld_o_valid = 1'b1; ld_o_rob_idx = 3'd0;
    tick();
    idle();
    #1;
    n_checks++;
    if (commit_valid !== 1'b1 || commit_rd !== 7'd50) begin
      n_fail++; $display("FAIL wrap_ret6 got cv=%0b rd=%0d want cv=1 rd=50", commit_valid, commit_rd);
    end
    tick();
    #1;
    n_checks++;
    if (commit_valid !== 1'b1 || commit_rd !== 7'd51) begin
      n_fail++; $display("FAIL wrap_ret7 got cv=%0b rd=%0d want cv=1 rd=51", commit_valid, commit_rd);
    end
    tick();
    #1;
    n_checks++;
    if (commit_valid !== 1'b0 || dut.count_q !== 4'd0) begin
      n_fail++; $display("FAIL wrap_stale got cv=%0b cnt=%0d want cv=0 cnt=0", commit_valid, dut.count_q);
    end
  endtask

  task automatic test_mis_simul();
    do_reset();
    dispatch(3'd0, 7'd60, 2'd0, 2'd0);
    dispatch(3'd5, 7'd61, 2'd1, 2'd2);
    dispatch(3'd0, 7'd62, 2'd3, 2'd3);
    dispatch(3'd0, 7'd63, 2'd3, 2'd3);
    alu_wb_valid = 1'b1; alu_wb_rob_idx = 3'd0;
    tick();
    idle();
    decode_valid = 1'b1; DC_rd = 7'd70;
    br_valid = 1'b1; br_rob_idx = 3'd1; br_mispredict = 1'b1;
    #1;
    n_checks++;
    if (commit_valid !== 1'b1 || commit_rd !== 7'd60 || flush_mask !== 8'b0000_1100) begin
      n_fail++; $display("FAIL simul_same got cv=%0b rd=%0d mask=%b want cv=1 rd=60 mask=00001100", commit_valid, commit_rd, flush_mask);
    end
    n_checks++;
    if (mis_ld_idx !== 2'd1 || mis_st_idx !== 2'd2) begin
      n_fail++; $display("FAIL simul_snap got ld=%0d st=%0d want ld=1 st=2", mis_ld_idx, mis_st_idx);
    end
    tick();
    idle();
    #1;
    n_checks++;
    if (DC_rob_idx !== 3'd2 || dut.count_q !== 4'd1) begin
      n_fail++; $display("FAIL simul_state got tail=%0d cnt=%0d want tail=2 cnt=1", DC_rob_idx, dut.count_q);
    end
    n_checks++;
    if (commit_valid !== 1'b1 || commit_rd !== 7'd61) begin
      n_fail++; $display("FAIL simul_br_ret got cv=%0b rd=%0d want cv=1 rd=61", commit_valid, commit_rd);
    end
    tick();
    #1;
    n_checks++;
    if (commit_valid !== 1'b0 || dut.count_q !== 4'd0) begin
      n_fail++; $display("FAIL simul_empty got cv=%0b cnt=%0d want cv=0 cnt=0", commit_valid, dut.count_q);
    end
  endtask

  initial begin
    rst = 1'b1;
    idle();
    #12 rst = 1'b0;
    tick();
    test_reset();
    test_fill();
    test_ooo();
    test_ldst();
    test_wrap_mispredict();
    test_mis_simul();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
